data_mem_responder: RTL

//  Data-memory responder on the memory-stage MR/MW interface: the memory end that

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_ram.sv | 33 +++
 rtl/data_mem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, op encoding, wait counter width.
// State WPOST only exists when DMEM_POSTED_WR_EN is defined.
package dmem_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
`ifdef DMEM_POSTED_WR_EN
        DONE   = 2'd2,
        WPOST  = 2'd3
`else
        DONE   = 2'd2
`endif
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM. Read data is registered and only moves on a read,
// so it can serve directly as the responder's read-data output.
module dmem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory end of the MR/MW interface: latches a request, waits WAIT_STATES cycles,
// performs the RAM access and pulses ready. Define DMEM_POSTED_WR_EN for early write ack.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MR,
    input  logic              MW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] W_MEM_OUT,
    output logic [DATA_W-1:0] W_MEM_IN,
    output logic              ready,
    output logic              busy
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    state_t            state;
    op_t               op;
    logic [WAIT_W-1:0] cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              ram_en;

`ifdef DMEM_POSTED_WR_EN
    assign ram_en = ((state == ACCESS) || (state == WPOST)) && (cnt == '0);
`else
    assign ram_en = (state == ACCESS) && (cnt == '0);
`endif

    assign busy = (state != IDLE);

    dmem_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .en   (ram_en),
        .we   (op == OP_WR),
        .addr (addr_q),
        .wdata(data_q),
        .rdata(W_MEM_IN)
    );

    // MR wins when both requests are high; the write is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op     <= OP_RD;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            ready  <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (MR || MW) begin
                        op     <= MR ? OP_RD : OP_WR;
                        addr_q <= addr;
                        data_q <= W_MEM_OUT;
                        cnt    <= WAIT_INIT;
`ifdef DMEM_POSTED_WR_EN
                        if (!MR) begin
                            ready <= 1'b1;
                            state <= WPOST;
                        end else begin
                            state <= ACCESS;
                        end
`else
                        state  <= ACCESS;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ready <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
`ifdef DMEM_POSTED_WR_EN
                // Write already acknowledged; just count down to the commit.
                WPOST: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
